axis_frame_fifo: RTL and testbench

- 8-bit AXI4-Stream FIFO placed directly downstream of the FIR filter stage; absorbs FIR output bursts and presents frames to the HPS-side DMA sink.
- Two modes: cut-through, where data leaves as soon as stored, and store-and-forward, where data is released only once a full frame (tlast) is buffered.
- APB slave exposes control, fill level, completed-frame count and stall count.

---
 rtl/axis_frame_fifo.sv | 139 +++++++++++++
 tb/tb_axis_frame_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo.sv
// 8-bit AXI4-Stream frame FIFO with cut-through and store-and-forward modes.
// APB slave exposes control, fill level, buffered frame count and stall count.
module axis_frame_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  axis4_s_tdata,
  input  logic        axis4_s_tvalid,
  output logic        axis4_s_tready,
  input  logic        axis4_s_tlast,
  output logic [7:0]  axis4_m_tdata,
  output logic        axis4_m_tvalid,
  input  logic        axis4_m_tready,
  output logic        axis4_m_tlast,
  input  logic [3:0]  apb_slave_paddr,
  input  logic        apb_slave_penable,
  output logic [31:0] apb_slave_prdata,
  input  logic [31:0] apb_slave_pwdata,
  input  logic        apb_slave_pwrite,
  input  logic        apb_slave_psel,
  output logic        apb_slave_pready
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   frames;
  logic          sf_mode;
  logic [31:0]   stall_cnt;

  logic [8:0] head;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       wr_en;
  logic       rd_en;
  logic       flush;
  logic       stall_clr;
  logic       lst_in;
  logic       lst_out;
  logic       unused;

  assign unused = ^{apb_slave_paddr[1:0], apb_slave_pwdata[31:2]};

  assign empty = (count == '0);
  assign full  = (count == FULL);
  assign head  = mem[rd_ptr];

  assign axis4_s_tready = ~full;
  // Full override keeps frames longer than DEPTH from deadlocking SF mode.
  assign axis4_m_tvalid = ~empty & (~sf_mode | (frames != '0) | full);
  assign axis4_m_tdata  = empty ? 8'h00 : head[7:0];
  assign axis4_m_tlast  = empty ? 1'b0 : head[8];

  assign push = axis4_s_tvalid & axis4_s_tready;
  assign pop  = axis4_m_tvalid & axis4_m_tready;

  assign wr_en = apb_slave_psel & apb_slave_penable & apb_slave_pwrite;
  assign rd_en = apb_slave_psel & apb_slave_penable & ~apb_slave_pwrite;

  assign flush     = wr_en & (apb_slave_paddr[3:2] == 2'd0)
                   & apb_slave_pwdata[1];
  assign stall_clr = wr_en & (apb_slave_paddr[3:2] == 2'd3);

  assign lst_in  = push & axis4_s_tlast;
  assign lst_out = pop & head[8];

  always_ff @(posedge clk) begin
    if (push & ~flush & ~rst)
      mem[wr_ptr] <= {axis4_s_tlast, axis4_s_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frames <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frames <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      unique case ({lst_in, lst_out})
        2'b10:   frames <= frames + 1'b1;
        2'b01:   frames <= frames - 1'b1;
        default: frames <= frames;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      sf_mode <= 1'b0;
    else if (wr_en & (apb_slave_paddr[3:2] == 2'd0))
      sf_mode <= apb_slave_pwdata[0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (axis4_s_tvalid & full & ~&stall_cnt)
      stall_cnt <= stall_cnt + 32'd1;
  end

  always_comb begin
    apb_slave_prdata = 32'h0;
    if (rd_en) begin
      unique case (apb_slave_paddr[3:2])
        2'd0: apb_slave_prdata = {31'h0, sf_mode};
        2'd1: apb_slave_prdata = {16'(frames), 16'(count)};
        2'd2: apb_slave_prdata = 32'(DEPTH);
        2'd3: apb_slave_prdata = stall_cnt;
        default: apb_slave_prdata = 32'h0;
      endcase
    end
  end

  assign apb_slave_pready = 1'b1;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_axis_frame_fifo;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  paddr;
  logic        penable;
  logic [31:0] prdata;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        pready;

  axis_frame_fifo #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .axis4_s_tdata     (s_data),
    .axis4_s_tvalid    (s_valid),
    .axis4_s_tready    (s_ready),
    .axis4_s_tlast     (s_last),
    .axis4_m_tdata     (m_data),
    .axis4_m_tvalid    (m_valid),
    .axis4_m_tready    (m_ready),
    .axis4_m_tlast     (m_last),
    .apb_slave_paddr   (paddr),
    .apb_slave_penable (penable),
    .apb_slave_prdata  (prdata),
    .apb_slave_pwdata  (pwdata),
    .apb_slave_pwrite  (pwrite),
    .apb_slave_psel    (psel),
    .apb_slave_pready  (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]  q [$];
  logic        sf;
  logic [31:0] stall;
  logic [31:0] last_rd;
  int          total;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int          n;
    int          fr;
    logic        e_rdy;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_lst;
    logic [31:0] e_rd;
    logic        push;
    logic        pop;
    logic        wr;
    #1;
    n  = q.size();
    fr = 0;
    foreach (q[i]) if (q[i][8]) fr++;
    e_rdy = (n != DEPTH);
    e_vld = (n != 0) && (!sf || fr != 0 || n == DEPTH);
    e_dat = (n != 0) ? q[0][7:0] : 8'h00;
    e_lst = (n != 0) ? q[0][8] : 1'b0;
    e_rd  = 32'h0;
    if (psel && penable && !pwrite) begin
      case (paddr[3:2])
        2'd0: e_rd = {31'h0, sf};
        2'd1: e_rd = {16'(fr), 16'(n)};
        2'd2: e_rd = 32'(DEPTH);
        default: e_rd = stall;
      endcase
    end
    last_rd = prdata;
    chk("s_tready", 32'(s_ready), 32'(e_rdy));
    chk("m_tvalid", 32'(m_valid), 32'(e_vld));
    chk("m_tdata",  32'(m_data),  32'(e_dat));
    chk("m_tlast",  32'(m_last),  32'(e_lst));
    chk("prdata",   prdata,       e_rd);
    chk("pready",   32'(pready),  32'h1);
    push = s_valid && e_rdy;
    pop  = e_vld && m_ready;
    wr   = psel && penable && pwrite;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      sf    = 1'b0;
      stall = 32'h0;
    end else begin
      if (wr && paddr[3:2] == 2'd3)
        stall = 32'h0;
      else if (s_valid && !e_rdy && stall != 32'hFFFF_FFFF)
        stall = stall + 1;
      if (wr && paddr[3:2] == 2'd0 && pwdata[1]) begin
        q.delete();
      end else begin
        if (pop)
          void'(q.pop_front());
        if (push)
          q.push_back({s_last, s_data});
      end
      if (wr && paddr[3:2] == 2'd0)
        sf = pwdata[0];
    end
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = a; pwdata = d;
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = a;
    cyc();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    cyc();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    total = 0; fails = 0;
    sf = 1'b0; stall = 32'h0; last_rd = 32'h0;
    rst = 1'b1;
    s_data = 8'h0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    paddr = 4'h0; penable = 1'b0; pwdata = 32'h0;
    pwrite = 1'b0; psel = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    idle(2);

    // cut-through
    m_ready = 1'b1;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b1);
    idle(3);
    apb_rd(4'h4);
    chk("ct_status", last_rd, 32'h0);

    // store-and-forward, 5-beat frame
    apb_wr(4'h0, 32'h1);
    for (int i = 0; i < 5; i++)
      beat(8'h40 + 8'(i), i == 4);
    apb_rd(4'h4);
    idle(6);
    apb_rd(4'h4);
    chk("sf_status", last_rd, 32'h0);
    apb_wr(4'h0, 32'h0);

    // full and stall
    m_ready = 1'b0;
    for (int i = 0; i < 70; i++)
      beat(8'(i * 3 + 1), 1'b0);
    apb_rd(4'hC);
    chk("stall6", last_rd, 32'd6);
    apb_rd(4'h8);
    chk("depth", last_rd, 32'd64);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    cyc();
    apb_wr(4'hC, 32'h0);
    apb_rd(4'hC);
    chk("stall_clr", last_rd, 32'h0);
    apb_wr(4'h0, 32'h2);

    // long frame in SF mode
    apb_wr(4'h0, 32'h1);
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++)
      beat(8'(8'hC0 ^ i), 1'b0);
    idle(70);
    apb_wr(4'h0, 32'h0);

    // flush
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      beat(8'(i + 8'h50), i == 4);
    apb_wr(4'h0, 32'h2);
    apb_rd(4'h4);
    chk("fl_status", last_rd, 32'h0);
    apb_rd(4'h0);
    chk("fl_ctrl", last_rd, 32'h0);
    m_ready = 1'b1;
    beat(8'hAA, 1'b1);
    idle(2);

    // simultaneous push and pop at count 1, wrapping pointers
    m_ready = 1'b0;
    beat(8'h01, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 80; i++)
      beat(8'(i + 2), 1'b0);
    m_ready = 1'b0;
    apb_rd(4'h4);
    chk("pp_status", last_rd, 32'h1);
    m_ready = 1'b1;
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      s_valid = ($urandom_range(0, 99) < 60);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 7) == 0);
      m_ready = ($urandom_range(0, 99) < 50);
      r = $urandom_range(0, 99);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      if (r < 3) begin
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr  = {2'($urandom), 2'b00};
        pwdata = $urandom;
      end else if (r < 20) begin
        psel = 1'b1; penable = 1'b1;
        paddr = {2'($urandom), 2'b00};
      end
      cyc();
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

    // reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      beat(8'(i + 8'h90), 1'b0);
    rst = 1'b1;
    s_valid = 1'b1;
    cyc();
    rst = 1'b0;
    s_valid = 1'b0;
    chk("rst_m_tvalid", 32'(m_valid), 32'h0);
    chk("rst_s_tready", 32'(s_ready), 32'h1);
    m_ready = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
